// File: rtl/pci_rw_control.sv
// PCI target command decode: latches the transaction direction at the address
// phase and gates it with DEVSEL#/IRDY# into read and write strobes.
module pci_rw_control (
    input  logic       Clock,
    input  logic       RST,
    input  logic       Frame,
    input  logic       Irdy,
    input  logic       Devsel,
    input  logic [3:0] CBE,
    output logic [1:0] rw,
    output logic       RE,
    output logic       WE
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    logic [0:0] state;

    always_ff @(posedge Clock) begin
        if (RST) begin
            state <= IDLE;
            rw    <= RW_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (!Frame) begin
                        // Unsupported commands still enter ACTIVE so their
                        // data phases pass by with the strobes held off.
                        state <= ACTIVE;
                        case (CBE)
                            CMD_MEM_RD: rw <= RW_READ;
                            CMD_MEM_WR: rw <= RW_WRITE;
                            default:    rw <= RW_NONE;
                        endcase
                    end else begin
                        rw <= RW_NONE;
                    end
                end
                ACTIVE: begin
                    // Frame high with Irdy low is the last data phase; only a
                    // fully idle bus ends the transaction.
                    if (Frame && Irdy) begin
                        state <= IDLE;
                        rw    <= RW_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    rw    <= RW_NONE;
                end
            endcase
        end
    end

    assign RE = (rw == RW_READ)  & ~Devsel & ~Irdy;
    assign WE = (rw == RW_WRITE) & ~Devsel & ~Irdy;

endmodule

// File: tb/tb_pci_rw_control.sv
// Directed vector bench for pci_rw_control: table of per-cycle inputs and
// expected outputs, plus hand sequences for mid-cycle strobe response.
module tb_pci_rw_control;

    logic       Clock = 1'b0;
    logic       RST, Frame, Irdy, Devsel;
    logic [3:0] CBE;
    logic [1:0] rw;
    logic       RE, WE;

    int total = 0;
    int bad   = 0;

    pci_rw_control dut (
        .Clock (Clock),
        .RST   (RST),
        .Frame (Frame),
        .Irdy  (Irdy),
        .Devsel(Devsel),
        .CBE   (CBE),
        .rw    (rw),
        .RE    (RE),
        .WE    (WE)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic       frame;
        logic       irdy;
        logic       devsel;
        logic [3:0] cbe;
        logic [1:0] exp_rw;
        logic       exp_re;
        logic       exp_we;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic i, input logic d, input logic [3:0] c);
        RST = r; Frame = f; Irdy = i; Devsel = d; CBE = c;
    endtask

    // Inputs change 1 unit after an edge and are held across the next edge;
    // outputs are sampled 1 unit after that edge.
    task automatic step(input logic r, input logic f, input logic i, input logic d, input logic [3:0] c);
        drive(r, f, i, d, c);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //                rst  frm  irdy dev  cbe    rw     re   we
        // reset held with a write command on the bus
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,4'h7,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,1'b1,4'h7,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});
        // write burst with Irdy and Devsel wait states
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,4'h7,2'b10,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'hF,2'b10,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0,2'b10,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,4'h0,2'b10,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,4'h0,2'b10,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0,2'b10,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h0,2'b10,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});
        // read burst
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,4'h6,2'b01,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0,2'b01,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h0,2'b01,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});
        // I/O read: ignored, CBE=6 during its data phase is not a new command
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,4'h2,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h6,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h7,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});
        // write, then Frame=0 with CBE=6 while active must not re-decode
        vecs.push_back('{1'b0,1'b0,1'b1,1'b1,4'h7,2'b10,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h6,2'b10,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0,2'b10,1'b0,1'b1});
        // reset mid-burst abandons the write
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,4'h0,2'b00,1'b0,1'b0});
        // next Frame=0 is an address phase; command 0 is unsupported
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h0,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});
        // Frame=1, Irdy=0 in idle is not an address phase
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,4'h7,2'b00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,4'h6,2'b01,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b1,4'h0,2'b00,1'b0,1'b0});

        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'h7);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].frame, vecs[i].irdy, vecs[i].devsel, vecs[i].cbe);
            chk($sformatf("v%0d_rw", i), {2'b00, rw}, {2'b00, vecs[i].exp_rw});
            chk($sformatf("v%0d_re", i), {3'b000, RE}, {3'b000, vecs[i].exp_re});
            chk($sformatf("v%0d_we", i), {3'b000, WE}, {3'b000, vecs[i].exp_we});
        end

        // Strobes follow Devsel/Irdy between edges with no register stage.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
        chk("seq_wr_rw", {2'b00, rw}, 4'h2);
        chk("seq_wr_idle_we", {3'b000, WE}, 4'h0);
        #2 Irdy = 1'b0; Devsel = 1'b0; #1;
        chk("seq_wr_comb_we_up", {3'b000, WE}, 4'h1);
        chk("seq_wr_comb_re", {3'b000, RE}, 4'h0);
        Devsel = 1'b1; #1;
        chk("seq_wr_comb_devsel", {3'b000, WE}, 4'h0);
        Devsel = 1'b0; Irdy = 1'b1; #1;
        chk("seq_wr_comb_irdy", {3'b000, WE}, 4'h0);
        Irdy = 1'b0; #1;
        chk("seq_wr_comb_back", {3'b000, WE}, 4'h1);
        // reset with the strobe active: drops right after the edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("seq_rst_rw", {2'b00, rw}, 4'h0);
        chk("seq_rst_we", {3'b000, WE}, 4'h0);
        // reset wins over an address phase with a read command
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h6);
        chk("seq_rst_hold_rw", {2'b00, rw}, 4'h0);
        chk("seq_rst_hold_re", {3'b000, RE}, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
        chk("seq_after_rst_rw", {2'b00, rw}, 4'h1);
        chk("seq_after_rst_re", {3'b000, RE}, 4'h1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
        chk("seq_end_rw", {2'b00, rw}, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
